// File: rtl/mult_seq_sm_if.sv
// Start/done handshake bundle for the sequential sign-magnitude multiplier.
// The master drives the request side; the slave (the multiplier) returns the result.
interface mult_seq_sm_if #(
  parameter int N = 32
);
  logic         local_reset;
  logic         start;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic [N-1:0] product;
  logic         busy;
  logic         done;
  logic         overflow;

  modport master (
    output local_reset, start, in1, in2,
    input  product, busy, done, overflow
  );

  modport slave (
    input  local_reset, start, in1, in2,
    output product, busy, done, overflow
  );
endinterface

// File: rtl/mult_seq_sm.sv
// Shift-add sign-magnitude Q-format multiplier, one multiplier bit per cycle.
// Optional MULT_SEQ_SM_ROUND_EN rounds half away from zero instead of truncating.
//
// state | meaning
// IDLE  | waiting for start; product/overflow hold last result
// CALC  | one partial product per cycle, N-1 cycles
// DONE  | scale, saturate, register product, pulse done
module mult_seq_sm #(
  parameter int Q = 16,
  parameter int N = 32
) (
  input logic            clk,
  input logic            reset,
  mult_seq_sm_if.slave   bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [2*N-3:0]  acc;
  logic [2*N-3:0]  mcand;
  logic [N-2:0]    mplier;
  logic            sign;
  logic [CW-1:0]   cnt;

  logic [N-2:0]    raw;
  logic [N-2:0]    mag;
  logic            ovf;
`ifdef MULT_SEQ_SM_ROUND_EN
  logic [N-1:0]    rnd;
`endif

  // Result scaling: drop Q fraction bits, anything above the N-1 magnitude bits is overflow.
  always_comb begin
    raw = acc[N-2+Q:Q];
    ovf = |acc[2*N-3:N-1+Q];
`ifdef MULT_SEQ_SM_ROUND_EN
    rnd = {1'b0, raw} + N'(acc[Q-1]);
    ovf = ovf | rnd[N-1];
    raw = rnd[N-2:0];
`endif
    mag = ovf ? '1 : raw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      sign         <= 1'b0;
      cnt          <= '0;
      bus.product  <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.overflow <= 1'b0;
    end else if (bus.local_reset) begin
      state        <= IDLE;
      bus.product  <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand        <= {{(N-1){1'b0}}, bus.in1[N-2:0]};
            mplier       <= bus.in2[N-2:0];
            sign         <= bus.in1[N-1] ^ bus.in2[N-1];
            acc          <= '0;
            cnt          <= '0;
            bus.overflow <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= CALC;
          end
        end
        CALC: begin
          if (mplier[cnt]) acc <= acc + mcand;
          mcand <= mcand << 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          // A zero magnitude always carries a positive sign.
          bus.product  <= {sign && (mag != '0), mag};
          bus.overflow <= ovf;
          bus.done     <= 1'b1;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_sm.sv
// Directed bench for mult_seq_sm: scoreboard of expected products, immediate-assertion checks.
module tb_mult_seq_sm;
  localparam int N = 32;
  localparam int Q = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  mult_seq_sm_if #(.N(N)) bus ();

  mult_seq_sm #(.Q(Q), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Expected {overflow, product} from integer multiply of magnitudes.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m;
    logic [30:0] mg;
    logic        ov;
    logic [31:0] r;
    m  = {33'b0, a[30:0]} * {33'b0, b[30:0]};
    ov = (m >> 47) != 64'd0;
    mg = m[46:16];
`ifdef MULT_SEQ_SM_ROUND_EN
    r  = {1'b0, mg} + {31'b0, m[15]};
    if (r[31]) ov = 1'b1;
    mg = r[30:0];
`endif
    if (ov) mg = '1;
    return {ov, (a[31] ^ b[31]) && (mg != 31'd0), mg};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit inject);
    int cyc;
    int bcnt;
    int d0;
    logic [32:0] exp;
    sb.push_back(model(a, b));
    @(negedge clk);
    bus.in1 = a; bus.in2 = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.in1 = $urandom; bus.in2 = $urandom;
    d0 = done_cnt; cyc = 0; bcnt = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.busy === 1'b1) bcnt++;
      if (inject && cyc == 5) begin
        bus.start = 1'b1; bus.in1 = 32'h0001_0000; bus.in2 = 32'h0003_0000;
      end
      if (inject && cyc == 6) bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(N));
    chk("busy_cycles", 64'(bcnt), 64'(N));
    chk("busy_at_done", 64'(bus.busy), 64'd0);
    exp = sb.pop_front();
    chk("product", 64'(bus.product), 64'(exp[31:0]));
    chk("overflow", 64'(bus.overflow), 64'(exp[32]));
    repeat (3) @(negedge clk);
    chk("done_pulse_count", 64'(done_cnt - d0), 64'd1);
    chk("product_held", 64'(bus.product), 64'(exp[31:0]));
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    bus.local_reset = 1'b0; bus.start = 1'b0; bus.in1 = '0; bus.in2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_product", 64'(bus.product), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    reset = 1'b0;

    run_op(32'h0001_8000, 32'h8002_0000, 1'b0);
    run_op(32'h0000_0000, 32'h8005_0000, 1'b0);
    run_op(32'h7FFF_0000, 32'h0002_0000, 1'b0);
    run_op(32'h7FFF_0000, 32'h8002_0000, 1'b0);
    run_op(32'h0000_0001, 32'h0000_8000, 1'b0);
    run_op(32'h8000_0001, 32'h0000_8000, 1'b0);
    run_op(32'h8002_4000, 32'h8000_C000, 1'b0);
    run_op(32'h0004_0000, 32'h0005_0000, 1'b1);
    for (int i = 0; i < 4; i++)
      run_op({1'($urandom), 7'd0, 24'($urandom)}, {1'($urandom), 7'd0, 24'($urandom)}, 1'b0);

    // Abort mid-CALC with a simultaneous start that must be dropped.
    @(negedge clk);
    bus.in1 = 32'h0003_0000; bus.in2 = 32'h0002_0000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    bus.local_reset = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.local_reset = 1'b0; bus.start = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_product", 64'(bus.product), 64'd0);
    chk("abort_overflow", 64'(bus.overflow), 64'd0);
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_idle_busy", 64'(bus.busy), 64'd0);
    run_op(32'h0003_0000, 32'h0002_0000, 1'b0);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    bus.in1 = 32'h0001_0000; bus.in2 = 32'h0001_0000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("areset_product", 64'(bus.product), 64'd0);
    chk("areset_busy", 64'(bus.busy), 64'd0);
    chk("areset_overflow", 64'(bus.overflow), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(32'h8001_0000, 32'h0002_8000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
